// File: rtl/full_adder_4bit_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_4bit_pkg;
  localparam int ADDER_WIDTH = 4;
endpackage

// File: rtl/full_adder_4bit_if.sv
// Operand/result bundle; master drives operands, slave returns registered result.
interface full_adder_4bit_if
  import full_adder_4bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) ();
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             out_valid;

  modport master (
    output in_valid, a, b, c_in,
    input  sum, c_out, overflow, zero, out_valid
  );

  modport slave (
    input  in_valid, a, b, c_in,
    output sum, c_out, overflow, zero, out_valid
  );
endinterface

// File: rtl/full_adder_4bit_1bit.sv
// One-bit full adder cell, chained by the top to form the ripple carry.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/full_adder_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry-out, signed overflow and zero flags.
module full_adder_4bit
  import full_adder_4bit_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  full_adder_4bit_if.slave bus
);
  localparam int STAGES = 1;

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;
  logic [STAGES:0]  vld_pipe;

  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_1bit u_fa (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (carry[i]),
      .s    (sum_c[i]),
      .cout (carry[i+1])
    );
  end

  assign vld_pipe[0] = bus.in_valid;

  // Result registers only load on accepted operands; out_valid tracks acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q              <= '0;
      c_out_q            <= 1'b0;
      ovf_q              <= 1'b0;
      zero_q             <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (bus.in_valid) begin
        sum_q   <= sum_c;
        c_out_q <= carry[WIDTH];
        ovf_q   <= carry[WIDTH] ^ carry[WIDTH-1];
        zero_q  <= (sum_c == '0);
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_full_adder_4bit.sv
// Scoreboard bench: driver pushes reference results, negedge monitor pops on out_valid.
module tb_full_adder_4bit;
  typedef struct {
    logic [3:0] sum;
    logic       c_out;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  full_adder_4bit_if #(.WIDTH(4)) bus ();

  full_adder_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input int a, input int b, input int ci);
    exp_t e;
    int full, sa, sb, ss;
    full   = a + b + ci;
    sa     = (a >= 8) ? a - 16 : a;
    sb     = (b >= 8) ? b - 16 : b;
    ss     = sa + sb + ci;
    e.sum  = 4'(full % 16);
    e.c_out = (full >= 16);
    e.ovf  = (ss > 7) || (ss < -8);
    e.zero = ((full % 16) == 0);
    return e;
  endfunction

  task automatic send(input int a, input int b, input int ci);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.a        = 4'(a);
    bus.b        = 4'(b);
    bus.c_in     = ci[0];
    sb_q.push_back(model(a, b, ci));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.a        = 4'($urandom_range(0, 15));
      bus.b        = 4'($urandom_range(0, 15));
      bus.c_in     = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".sum"},       32'(bus.sum),       32'd0);
    chk({tag, ".c_out"},     32'(bus.c_out),     32'd0);
    chk({tag, ".overflow"},  32'(bus.overflow),  32'd0);
    chk({tag, ".zero"},      32'(bus.zero),      32'd0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {25'd0, bus.c_out, bus.overflow, bus.zero, bus.sum},
            {25'd0, e.c_out, e.ovf, e.zero, e.sum});
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_zero_outs("reset_init");
    @(negedge clk) rst_n = 1'b1;
    idle(2);
    @(negedge clk);
    chk("post_release_out_valid", 32'(bus.out_valid), 32'd0);

    // directed and boundary vectors
    send(4'b1001, 4'b1000, 1);
    send(4'b1011, 4'b1010, 0);
    send(4'b1000, 4'b1100, 1);
    send(4'b1101, 4'b1110, 0);
    send(4'b1111, 4'b0000, 1);
    send(4'b0111, 4'b0000, 1);
    send(0, 0, 0);
    send(15, 15, 1);

    // hold
    send(4'b0011, 4'b0100, 0);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus.a = 4'($urandom_range(0, 15));
      bus.b = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("hold.sum", 32'(bus.sum), 32'd7);
      chk("hold.out_valid", 32'(bus.out_valid), 32'd0);
    end

    // in-flight result discarded by asynchronous reset mid-cycle
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = 4'd5; bus.b = 4'd6; bus.c_in = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_zero_outs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.c_in = 1'b1;
    sb_q.push_back(model(9, 3, 1));

    // exhaustive back-to-back
    for (int i = 0; i < 512; i++) send(i[3:0], i[7:4], int'(i[8]));
    // randomized with idle gaps
    for (int i = 0; i < 200; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
